// File: rtl/gpio_bank.sv
// GPIO bank: NCH channels of WIDTH-bit I/O with set/clear/toggle output writes,
// synchronised inputs, edge-detect sticky status and one registered interrupt.

module gpio_bank_ch #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             we,
  input  logic [2:0]       rsel,
  input  logic [WIDTH-1:0] wd,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] out,
  output logic             hit
);
  logic [WIDTH-1:0] s1_q, s2_q, s3_q, out_q, ien_q, stat_q, edge_q;
  logic [WIDTH-1:0] s1_d, s2_d, s3_d, out_d, ien_d, stat_d, edge_d;
  logic [WIDTH-1:0] evt, clr;

  always_comb begin
    s1_d   = pin;
    s2_d   = s1_q;
    s3_d   = s2_q;
    out_d  = out_q;
    ien_d  = ien_q;
    edge_d = edge_q;
    clr    = '0;
    // Only s2/s3 transitions produce events, so rewriting EDGE alone is harmless.
    evt    = (edge_q & s2_q & ~s3_q) | (~edge_q & ~s2_q & s3_q);
    if (sel && we) begin
      case (rsel)
        3'd1:    out_d  = wd;
        3'd2:    out_d  = out_q | wd;
        3'd3:    out_d  = out_q & ~wd;
        3'd4:    out_d  = out_q ^ wd;
        3'd5:    ien_d  = wd;
        3'd6:    clr    = wd;
        3'd7:    edge_d = wd;
        default: ;
      endcase
    end
    // A new event in the same cycle as a W1C keeps the bit set.
    stat_d = (stat_q & ~clr) | evt;
  end

  always_comb begin
    rdata = '0;
    case (rsel)
      3'd0:    rdata = s2_q;
      3'd1:    rdata = out_q;
      3'd5:    rdata = ien_q;
      3'd6:    rdata = stat_q;
      3'd7:    rdata = edge_q;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      out_q  <= '0;
      ien_q  <= '0;
      stat_q <= '0;
      edge_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      out_q  <= out_d;
      ien_q  <= ien_d;
      stat_q <= stat_d;
      edge_q <= edge_d;
    end
  end

  assign out = out_q;
  assign hit = |(stat_q & ien_q);
endmodule

module gpio_bank #(
  parameter int WIDTH = 32,
  parameter int NCH   = 2,
  parameter int AW    = $clog2(NCH) + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        A,
  input  logic                 WE,
  input  logic [WIDTH-1:0]     WD,
  input  logic [NCH*WIDTH-1:0] gpI,
  output logic [WIDTH-1:0]     RD,
  output logic [NCH*WIDTH-1:0] gpO,
  output logic                 irq
);
  localparam int CW = (AW > 3) ? AW - 3 : 1;

  logic [CW-1:0]                ch_sel;
  logic [NCH-1:0]               sel, hit;
  logic [NCH-1:0][WIDTH-1:0]    rd_ch, out_ch;
  logic [WIDTH-1:0]             rd_d, rd_q;
  logic                         irq_d, irq_q;

  generate
    if (AW > 3) begin : g_dec
      assign ch_sel = A[AW-1:3];
    end else begin : g_one
      assign ch_sel = '0;
    end
  endgenerate

  // Unpopulated channel numbers match no sel bit, so they read 0 and ignore writes.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign sel[c] = (ch_sel == CW'(c));
    gpio_bank_ch #(.WIDTH(WIDTH)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .sel   (sel[c]),
      .we    (WE),
      .rsel  (A[2:0]),
      .wd    (WD),
      .pin   (gpI[c*WIDTH +: WIDTH]),
      .rdata (rd_ch[c]),
      .out   (out_ch[c]),
      .hit   (hit[c])
    );
  end

  always_comb begin
    rd_d = '0;
    for (int c = 0; c < NCH; c++)
      if (sel[c]) rd_d = rd_ch[c];
    irq_d = |hit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      irq_q <= irq_d;
    end
  end

  assign RD  = rd_q;
  assign irq = irq_q;
  assign gpO = out_ch;
endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank (NCH=3): expectations queued with stimulus,
// compared after the clock edge they refer to.

module tb_gpio_bank;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  A;
  logic        WE;
  logic [31:0] WD;
  logic [95:0] gpI;
  logic [31:0] RD;
  logic [95:0] gpO;
  logic        irq;

  gpio_bank #(.WIDTH(32), .NCH(3)) dut (
    .clk(clk), .rst(rst), .A(A), .WE(WE), .WD(WD),
    .gpI(gpI), .RD(RD), .gpO(gpO), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;   // 0 RD, 1 irq, 2 gpO
    logic [95:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int kind, input logic [95:0] e);
    exp_t t;
    t.tag = tag; t.kind = kind; t.exp = e;
    sbq.push_back(t);
  endtask

  task automatic step();
    exp_t t;
    @(posedge clk);
    @(negedge clk);
    while (sbq.size() > 0) begin
      t = sbq.pop_front();
      case (t.kind)
        0:       chk(t.tag, {64'b0, RD}, t.exp);
        1:       chk(t.tag, {95'b0, irq}, t.exp);
        default: chk(t.tag, gpO, t.exp);
      endcase
    end
  endtask

  function automatic logic [4:0] addr(input int ch, input int r);
    return {ch[1:0], r[2:0]};
  endfunction

  task automatic wr(input int ch, input int r, input logic [31:0] d);
    A = addr(ch, r); WE = 1'b1; WD = d;
    step();
    WE = 1'b0; WD = '0;
  endtask

  task automatic rd(input int ch, input int r, input logic [31:0] e, input string tag);
    A = addr(ch, r);
    push(tag, 0, {64'b0, e});
    step();
  endtask

  initial begin
    logic [31:0] v, prev;
    rst = 1'b0; A = '0; WE = 1'b0; WD = '0; gpI = '0;
    repeat (2) @(negedge clk);
    chk("rst_rd", {64'b0, RD}, 96'h0);
    chk("rst_gpo", gpO, 96'h0);
    chk("rst_irq", {95'b0, irq}, 96'h0);
    rst = 1'b1;
    step();

    // Mid-run asynchronous reset
    push("pre_gpo", 2, {64'h0, 32'hFFFF_FFFF});
    wr(0, 1, 32'hFFFF_FFFF);
    rd(0, 1, 32'hFFFF_FFFF, "pre_rd");
    #2 rst = 1'b0;
    #1;
    chk("mid_gpo", gpO, 96'h0);
    chk("mid_rd", {64'b0, RD}, 96'h0);
    chk("mid_irq", {95'b0, irq}, 96'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 8; r++)
        rd(c, r, 32'h0, $sformatf("rst_reg_c%0d_r%0d", c, r));

    // Output modes on channel 1
    push("out_f0", 2, {32'h0, 32'hF0, 32'h0});
    wr(1, 1, 32'hF0);
    push("set_0f", 2, {32'h0, 32'hFF, 32'h0});
    wr(1, 2, 32'h0F);
    push("clr_30", 2, {32'h0, 32'hCF, 32'h0});
    wr(1, 3, 32'h30);
    push("tgl_81", 2, {32'h0, 32'h4E, 32'h0});
    wr(1, 4, 32'h81);
    rd(1, 2, 32'h0, "rd_set");
    rd(1, 3, 32'h0, "rd_clr");
    rd(1, 4, 32'h0, "rd_tgl");
    rd(1, 1, 32'h4E, "rd_out");

    // Rising edge on bit 0
    wr(0, 7, 32'h1);
    wr(0, 5, 32'h1);
    A = addr(0, 0); gpI[0] = 1'b1;
    push("rise_in_e1", 0, 96'h0); push("rise_irq_e1", 1, 96'h0); step();
    push("rise_in_e2", 0, 96'h0); push("rise_irq_e2", 1, 96'h0); step();
    push("rise_in_e3", 0, 96'h1); push("rise_irq_e3", 1, 96'h0); step();
    A = addr(0, 6);
    push("rise_stat_e4", 0, 96'h1); push("rise_irq_e4", 1, 96'h1); step();
    push("w1c_irq_n", 1, 96'h1);
    wr(0, 6, 32'h1);
    push("w1c_irq_n1", 1, 96'h0);
    rd(0, 6, 32'h0, "w1c_stat");
    gpI[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push($sformatf("fall_noevt_irq%0d", i), 1, 96'h0);
      step();
    end
    rd(0, 6, 32'h0, "fall_noevt_stat");

    // Falling edge on bit 5, masked
    wr(0, 7, 32'h0);
    wr(0, 5, 32'h0);
    gpI[5] = 1'b1;
    repeat (4) step();
    gpI[5] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push($sformatf("mask_irq%0d", i), 1, 96'h0);
      step();
    end
    rd(0, 6, 32'h20, "mask_stat");
    push("ien_irq_n", 1, 96'h0);
    wr(0, 5, 32'h20);
    A = addr(0, 6);
    push("ien_irq_n1", 1, 96'h1);
    step();

    // W1C colliding with a fresh rise on bit 0
    wr(0, 7, 32'h1);
    wr(0, 5, 32'h1);
    wr(0, 6, 32'h20);
    A = addr(0, 6);
    push("col_pre_irq", 1, 96'h0);
    step();
    gpI[0] = 1'b1;
    repeat (3) step();
    push("col_first_irq", 1, 96'h1);
    step();
    gpI[0] = 1'b0;
    repeat (4) step();
    gpI[0] = 1'b1;
    step();
    step();
    push("col_irq_n", 1, 96'h1);
    wr(0, 6, 32'h1);
    push("col_irq_n1", 1, 96'h1);
    rd(0, 6, 32'h1, "col_stat");

    // Unpopulated channel 3
    push("oor_gpo_a", 2, {32'h0, 32'h4E, 32'h0});
    wr(3, 0, 32'hDEAD_BEEF);
    push("oor_gpo_b", 2, {32'h0, 32'h4E, 32'h0});
    wr(3, 1, 32'hDEAD_BEEF);
    rd(3, 0, 32'h0, "oor_rd_in");
    rd(3, 1, 32'h0, "oor_rd_out");
    rd(1, 1, 32'h4E, "oor_ch1_out");

    // Channel 2 IN tracks pins
    prev = 32'h0;
    for (int k = 0; k < 2; k++) begin
      v = $urandom;
      if (v == prev) v = ~prev;
      A = addr(2, 0);
      gpI[95:64] = v;
      push($sformatf("c2_in%0d_e1", k), 0, {64'b0, prev}); step();
      push($sformatf("c2_in%0d_e2", k), 0, {64'b0, prev}); step();
      push($sformatf("c2_in%0d_e3", k), 0, {64'b0, v});    step();
      prev = v;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised general-purpose I/O bank for the memory-mapped peripheral space. It provides NCH channels of WIDTH-bit inputs and outputs, with atomic set/clear/toggle output writes. Inputs pass through a two-flop synchroniser and an edge detector. Detected edges latch into sticky, maskable interrupt status with write-1-to-clear, and a single registered interrupt line feeds the interrupt controller.

## Interface
- WIDTH, 32: bits per channel (also data bus width)
- NCH, 2: number of channels, 1..8
- AW, $clog2(NCH)+3: word-address width; A[AW-1:3] selects the channel, A[2:0] selects the register
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- A  in  AW  word address
- WE  in  1  write strobe, one write per cycle
- WD  in  WIDTH  write data
- gpI  in  NCH*WIDTH  raw input pins; channel c occupies [c*WIDTH +: WIDTH]; asynchronous to clk
- RD  out  WIDTH  registered read data
- gpO  out  NCH*WIDTH  output registers, same packing as gpI
- irq  out  1  registered interrupt, OR of all channels' (STAT & IEN)

## Operation
- Register map per channel (A[2:0]):
  - 0 IN: RO; synchronised input
  - 1 OUT: RW; write replaces the value
  - 2 SET: WO; OUT <= OUT | WD; reads 0
  - 3 CLR: WO; OUT <= OUT & ~WD; reads 0
  - 4 TGL: WO; OUT <= OUT ^ WD; reads 0
  - 5 IEN: RW; per-bit interrupt enable
  - 6 STAT: RO sticky; a write clears bits where WD=1 (W1C)
  - 7 EDGE: RW; per bit, 1 = rising-edge detect, 0 = falling-edge detect
- Writes to IN, and reads or writes to channels ≥ NCH:
  - writes have no effect
  - reads return 0
- Synchroniser chain, per bit:
  - s1 <= gpI, s2 <= s1, s3 <= s2
  - IN = s2
  - rise = s2 & ~s3, fall = ~s2 & s3
  - evt = EDGE ? rise : fall
- STAT update: STAT <= (STAT & ~clr) | evt, where clr = WD when a W1C write targets this channel, else 0. Set wins over a simultaneous clear of the same bit.
- Edge detection runs regardless of IEN. IEN only gates irq.
- Changing EDGE never creates an event by itself. Events come only from s2/s3 transitions.
- irq <= |(STAT & IEN) over all channels.
- RD <= read value selected by A, every cycle, independent of WE.

## Timing
- Reset value of every state element and output is 0: gpO, RD, irq, IEN, STAT, EDGE, s1, s2, s3. Reset takes effect immediately, mid-cycle, and overrides any in-flight write.
- Write latency: WE high at edge n → register or gpO updated after edge n.
- Read latency: A presented before edge n → RD valid after edge n.
  - A read of a register written at edge n returns the new value when A is held through edge n+1.
- Input path, for a pin that toggles and is stable before edge 1:
  - s1 updates at edge 1
  - IN updates at edge 2
  - STAT bit sets at edge 3
  - irq asserts at edge 4 (if IEN)
  - RD shows IN when read at edge 3 or later
- W1C of the last pending STAT bit at edge n → irq deasserts after edge n+1.
- Pulses shorter than one clk period may be missed. This is not a bug.

## Test plan
- Reset values: assert rst low mid-run after writing OUT=0xFFFF_FFFF → gpO, RD, irq = 0 immediately; all registers read 0 after release.
- Output modes, channel 1:
  - write OUT=0x0000_00F0, then SET 0x0F, CLR 0x30, TGL 0x81
  - gpO[63:32] steps through 0xF0, 0xFF, 0xCF, 0x4E
  - reads of SET, CLR and TGL return 0
- Rising edge:
  - channel 0, EDGE=0x1, IEN=0x1; gpI[0] 0→1
  - STAT=0x1 at edge 3, irq=1 at edge 4
  - gpI[0] 1→0 sets nothing
- Falling edge with masking:
  - EDGE=0, IEN=0; gpI[5] 1→0 → STAT=0x20, irq stays 0
  - write IEN=0x20 → irq=1 one edge later
- W1C collision: W1C 0x1 in the same cycle that a new rise is detected on bit 0 → STAT bit 0 stays 1 and irq stays high.
- Out-of-range channel (NCH=3): write to A=0x18 → no state change, RD=0; read of channel 2 IN tracks gpI[95:64] with 2-cycle latency.
